// File: rtl/btn_debounce_if.sv
// Button-conditioning bus: raw buttons in, debounced level / press pulse / pending status out.
interface btn_debounce_if #(
  parameter int NUM_BTN = 3
);
  logic [NUM_BTN-1:0] btn;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] trig;
  logic [NUM_BTN-1:0] pend;

  modport master (input btn, output level, trig, pend);
  modport slave  (output btn, input level, trig, pend);
endinterface

// File: rtl/btn_debounce.sv
// Synchronise, debounce and serialise push-button presses for the vending FSM.
// Optional macro BTN_AUTOREPEAT_EN adds per-channel auto-repeat while a button is held.
module btn_db_lane #(
  parameter int CNT_W     = 20,
  parameter int DB_CYCLES = 1000000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int RPT_DELAY  = 50000000,
  parameter int RPT_PERIOD = 10000000
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);
  logic             r_s1, r_s2, r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_flip, w_press;

  // Level accepts the new value on the DB_CYCLES-th consecutive differing sample.
  assign w_flip  = (r_s2 != r_level) && (r_cnt == CNT_W'(DB_CYCLES - 1));
  assign w_press = w_flip && !r_level;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if ((r_s2 == r_level) || w_flip) r_cnt <= '0;
      else                             r_cnt <= r_cnt + 1'b1;
      if (w_flip) r_level <= ~r_level;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  logic [31:0] r_rcnt;
  logic        r_first;
  logic        w_rpt;

  // r_first selects the long initial delay, later repeats use the period.
  assign w_rpt = r_level &&
                 (r_rcnt == (r_first ? 32'(RPT_DELAY - 1) : 32'(RPT_PERIOD - 1)));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rcnt  <= '0;
      r_first <= 1'b1;
    end else if (!r_level || w_flip) begin
      r_rcnt  <= '0;
      r_first <= 1'b1;
    end else if (w_rpt) begin
      r_rcnt  <= '0;
      r_first <= 1'b0;
    end else begin
      r_rcnt  <= r_rcnt + 32'd1;
    end
  end

  assign o_rise = w_press | w_rpt;
`else
  assign o_rise = w_press;
`endif

  assign o_level = r_level;
endmodule

module btn_debounce #(
  parameter int NUM_BTN    = 3,
  parameter int CNT_W      = 20,
  parameter int DB_CYCLES  = 1000000,
  parameter int RPT_DELAY  = 50000000,
  parameter int RPT_PERIOD = 10000000
) (
  input  logic           clk,
  input  logic           rst,
  btn_debounce_if.master bus
);
  logic [NUM_BTN-1:0] w_level, w_rise, w_grant;
  logic [NUM_BTN-1:0] r_pend, r_trig;

  if (DB_CYCLES < 1 || longint'(DB_CYCLES) > ((64'sd1 <<< CNT_W) - 64'sd1)
      || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_param_chk
    $error("btn_debounce: illegal parameter combination");
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    btn_db_lane #(
      .CNT_W      (CNT_W),
      .DB_CYCLES  (DB_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD)
`endif
    ) u_lane (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_btn   (bus.btn[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  // Isolate the lowest set pend bit: index 0 has issue priority.
  assign w_grant = r_pend & (~r_pend + NUM_BTN'(1));

  // A rise on the same edge as the grant wins, so the press is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      r_trig <= '0;
    end else begin
      r_pend <= (r_pend & ~w_grant) | w_rise;
      r_trig <= w_grant;
    end
  end

  assign bus.level = w_level;
  assign bus.trig  = r_trig;
  assign bus.pend  = r_pend;
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random button traffic against a sample-window model.
module tb_btn_debounce;
  localparam int NB = 3;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_debounce_if #(.NUM_BTN(NB)) bus ();

  btn_debounce #(
    .NUM_BTN(NB), .CNT_W(8), .DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: level flips once the last DB synchronised samples all disagree with it.
  logic [NB-1:0] m_level, m_pend, m_trig;
  logic [15:0]   m_hist [NB];
  int            m_age  [NB];

  task automatic model_reset();
    m_level = '0; m_pend = '0; m_trig = '0;
    for (int c = 0; c < NB; c++) begin m_hist[c] = '0; m_age[c] = 0; end
  endtask

  // One clock edge: update the model at posedge, return at the following negedge.
  task automatic step();
    logic [NB-1:0] rise, grant, nlev;
    bit stable;
    @(posedge clk);
    if (rst) begin
      rise = '0; grant = '0; nlev = m_level;
      for (int c = 0; c < NB; c++) begin
        m_hist[c] = {m_hist[c][14:0], bus.btn[c]};
        stable = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (m_hist[c][k] == m_level[c]) stable = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        if (m_level[c]) begin
          m_age[c]++;
          if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0)) rise[c] = 1'b1;
        end
        if (stable && !m_level[c]) m_age[c] = 0;
`endif
        if (stable) begin
          nlev[c] = ~m_level[c];
          if (!m_level[c]) rise[c] = 1'b1;
        end
      end
      for (int c = 0; c < NB; c++)
        if (m_pend[c] && grant == '0) grant[c] = 1'b1;
      m_trig  = grant;
      m_pend  = (m_pend & ~grant) | rise;
      m_level = nlev;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.btn = 3'b111;
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if ({bus.level, bus.trig, bus.pend} !== 9'b0) begin
        fails++;
        $display("FAIL reset_hold: got lvl=%b trig=%b pend=%b, want all 0", bus.level, bus.trig, bus.pend);
      end
    end
    bus.btn = 3'b000;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if ({bus.level, bus.trig, bus.pend} !== 9'b0) begin
        fails++;
        $display("FAIL reset_release: got lvl=%b trig=%b pend=%b, want all 0", bus.level, bus.trig, bus.pend);
      end
    end
  endtask

  task automatic idle(input int n);
    bus.btn = '0;
    for (int i = 0; i < n; i++) begin
      step();
      tests++;
      if ({bus.level, bus.trig, bus.pend} !== {m_level, m_trig, m_pend}) begin
        fails++;
        $display("FAIL idle: got lvl=%b trig=%b pend=%b, want %b %b %b",
                 bus.level, bus.trig, bus.pend, m_level, m_trig, m_pend);
      end
    end
  endtask

  task automatic test_clean_press();
    int extra;
    bus.btn = 3'b001;
    for (int e = 1; e <= 12; e++) begin
      step();
      tests++;
      if ({bus.level, bus.trig, bus.pend} !== {m_level, m_trig, m_pend}) begin
        fails++;
        $display("FAIL clean_model e%0d: got lvl=%b trig=%b pend=%b, want %b %b %b",
                 e, bus.level, bus.trig, bus.pend, m_level, m_trig, m_pend);
      end
      if (e == 5 || e == 6) begin
        tests++;
        if (bus.level[0] !== (e == 6)) begin
          fails++;
          $display("FAIL clean_level e%0d: got %b want %b", e, bus.level[0], (e == 6));
        end
      end
      if (e == 6 || e == 7 || e == 8) begin
        tests++;
        if (bus.trig !== ((e == 7) ? 3'b001 : 3'b000)) begin
          fails++;
          $display("FAIL clean_trig e%0d: got %b want %b", e, bus.trig, (e == 7) ? 3'b001 : 3'b000);
        end
      end
    end
    extra = 0;
    for (int e = 13; e <= 24; e++) begin
      step();
      if (bus.trig != '0) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL clean_held: got %0d extra trig pulses want 0", extra);
    end
    idle(10);
  endtask

  task automatic test_glitch();
    bus.btn = 3'b010;
    for (int e = 1; e <= 16; e++) begin
      if (e == 4) bus.btn = 3'b000;
      step();
      tests++;
      if (bus.level[1] !== 1'b0 || bus.trig !== 3'b000 || bus.pend !== m_pend) begin
        fails++;
        $display("FAIL glitch e%0d: got lvl=%b trig=%b pend=%b, want lvl[1]=0 trig=000 pend=%b",
                 e, bus.level, bus.trig, bus.pend, m_pend);
      end
    end
  endtask

  task automatic test_collision();
    bus.btn = 3'b110;
    for (int e = 1; e <= 10; e++) begin
      step();
      tests++;
      if ({bus.level, bus.trig, bus.pend} !== {m_level, m_trig, m_pend}) begin
        fails++;
        $display("FAIL collision_model e%0d: got lvl=%b trig=%b pend=%b, want %b %b %b",
                 e, bus.level, bus.trig, bus.pend, m_level, m_trig, m_pend);
      end
      if (e == 6) begin
        tests++;
        if (bus.pend !== 3'b110) begin
          fails++; $display("FAIL collision_pend6: got %b want 110", bus.pend);
        end
      end
      if (e == 7) begin
        tests++;
        if (bus.trig !== 3'b010) begin
          fails++; $display("FAIL collision_trig7: got %b want 010", bus.trig);
        end
      end
      if (e == 8) begin
        tests++;
        if (bus.trig !== 3'b100 || bus.pend !== 3'b000) begin
          fails++; $display("FAIL collision_e8: got trig=%b pend=%b want 100 000", bus.trig, bus.pend);
        end
      end
    end
    idle(10);
  endtask

  task automatic test_async_reset();
    bus.btn = 3'b100;
    for (int e = 1; e <= 3; e++) step();
    rst = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({bus.level, bus.trig, bus.pend} !== 9'b0) begin
      fails++;
      $display("FAIL async_reset_now: got lvl=%b trig=%b pend=%b want all 0", bus.level, bus.trig, bus.pend);
    end
    step();
    step();
    rst = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      tests++;
      if ({bus.level, bus.trig, bus.pend} !== {m_level, m_trig, m_pend}) begin
        fails++;
        $display("FAIL async_model e%0d: got lvl=%b trig=%b pend=%b, want %b %b %b",
                 e, bus.level, bus.trig, bus.pend, m_level, m_trig, m_pend);
      end
      if (e == 6 || e == 7) begin
        tests++;
        if (bus.trig[2] !== (e == 7)) begin
          fails++; $display("FAIL async_trig e%0d: got %b want %b", e, bus.trig[2], (e == 7));
        end
      end
    end
    idle(10);
  endtask

  task automatic test_autorepeat();
    int pulses;
    int want;
    pulses = 0;
    bus.btn = 3'b001;
    for (int e = 1; e <= 69; e++) begin
      if (e == 58) bus.btn = 3'b000;
      step();
      if (bus.trig[0]) pulses++;
      tests++;
      if ({bus.level, bus.trig, bus.pend} !== {m_level, m_trig, m_pend}) begin
        fails++;
        $display("FAIL autorepeat_model e%0d: got lvl=%b trig=%b pend=%b, want %b %b %b",
                 e, bus.level, bus.trig, bus.pend, m_level, m_trig, m_pend);
      end
    end
`ifdef BTN_AUTOREPEAT_EN
    want = 6;
`else
    want = 1;
`endif
    tests++;
    if (pulses != want) begin
      fails++;
      $display("FAIL autorepeat_count: got %0d pulses want %0d", pulses, want);
    end
    idle(8);
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 80; seg++) begin
      bus.btn = NB'($urandom);
      hold = $urandom_range(1, 12);
      for (int i = 0; i < hold; i++) begin
        step();
        tests++;
        if ({bus.level, bus.trig, bus.pend} !== {m_level, m_trig, m_pend}) begin
          fails++;
          $display("FAIL random seg%0d: got lvl=%b trig=%b pend=%b, want %b %b %b",
                   seg, bus.level, bus.trig, bus.pend, m_level, m_trig, m_pend);
        end
      end
    end
    idle(12);
  endtask

  initial begin
    bus.btn = '0;
    model_reset();
    test_reset();
    test_clean_press();
    test_glitch();
    test_collision();
    test_async_reset();
    test_autorepeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-conditioning stage that sits directly upstream of the coin/select vending FSM.
- Takes the raw, asynchronous push buttons (A=50, B=100, C=select) and synchronises and debounces each one.
- Produces a clean level plus a single-cycle press pulse per button.
- Colliding presses are serialised so that at most one trigger reaches the FSM per cycle and no coin is lost.

Parameters:
- NUM_BTN, 3: number of button channels; index 0 has the highest issue priority.
- CNT_W, 20: width of each per-channel debounce counter; must satisfy DB_CYCLES <= 2^CNT_W - 1.
- DB_CYCLES, 1000000: number of consecutive stable synchronised samples required to accept a level change; minimum 1.
- RPT_DELAY, 50000000: cycles from accepted press to the first auto-repeat; used only when BTN_AUTOREPEAT_EN is defined.
- RPT_PERIOD, 10000000: cycles between subsequent auto-repeats; used only when BTN_AUTOREPEAT_EN is defined.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- btn  input  NUM_BTN  raw button inputs, asynchronous to clk, active-high.
- level  output  NUM_BTN  debounced button level.
- trig  output  NUM_BTN  one-cycle press pulse; at most one bit set per cycle.
- pend  output  NUM_BTN  presses accepted but not yet issued on trig (status only).

Behaviour:
- Reset: rst=0 asynchronously clears the sync flops, counters, level, pend and trig to all zeros. Outputs stay 0 until rst=1.
- Synchroniser: two flops per channel; the synchronised value s2 is visible after the 2nd edge sampling a new btn value.
- Debounce, per channel:
  - If s2 != level, cnt increments.
  - If s2 == level, cnt clears to 0.
  - When s2 != level and cnt == DB_CYCLES-1, level toggles and cnt clears on that edge.
  - Net effect: a stable btn change is reflected on level exactly DB_CYCLES+2 edges after the first edge that samples it.
- Glitch rejection: any btn excursion shorter than DB_CYCLES synchronised samples leaves level unchanged. The counter restarts from 0 on every reversal.
- Press detection:
  - A 0->1 transition of level sets the channel's pend bit on the same edge.
  - A 1->0 transition (release) generates nothing.
- Issue arbiter:
  - Each edge, if pend != 0, trig gets a one-hot of the lowest-index set pend bit, and that pend bit clears on the same edge.
  - Otherwise trig = 0. trig is registered, so a press appears on trig exactly 1 edge after pend sets when no older pend is waiting.
- Simultaneous events:
  - Two channels accepting a press on the same edge issue on consecutive cycles, lowest index first.
  - A new rise on a channel whose pend bit is already set is merged (no counting). The same applies to a bit set and cleared on the same edge: the rise wins and pend stays 1.
- Held button: no further trig while level stays 1, unless auto-repeat is enabled.
- Reset release with a button held: treated as a fresh press; trig fires DB_CYCLES+3 edges after reset release.
- Reset mid-operation discards all pending presses.
- No combinational path from btn to any output.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Per-channel repeat counter of width 32.
  - While level=1, a repeat rise is injected into pend RPT_DELAY cycles after the accepted press, then every RPT_PERIOD cycles.
  - The counter clears when level falls or on reset.
  - Injected rises follow the same merge and arbitration rules.
- Undefined: no repeat logic is synthesised; RPT_DELAY and RPT_PERIOD are ignored; exactly one trig per accepted press.

Test Plan (NUM_BTN=3, DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8):
- Reset check: hold rst=0 with btn=3'b111 -> level, trig, pend all 0. Release rst with btn=3'b000 -> outputs remain 0.
- Clean press: btn[0]=1 held from edge 0 -> level[0]=1 after edge 6; trig=3'b001 for exactly one cycle after edge 7; no further trig while held.
- Glitch: btn[1] high for 3 cycles then low -> level[1] and trig stay 0 throughout.
- Collision: btn[1] and btn[2] rise on the same edge -> pend=3'b110 after edge 6; trig=3'b010 after edge 7, then trig=3'b100 after edge 8; pend=0 after edge 8.
- Async reset mid-debounce: btn[2]=1, rst pulsed low at edge 3 -> all state cleared immediately. After release, trig[2] is asserted 7 edges later.
- BTN_AUTOREPEAT_EN defined, btn[0] held 60 cycles -> trig[0] pulses at the initial press, then 20 cycles later, then every 8 cycles until release. Undefined -> a single pulse only.
